// File: rtl/jedro_1_data_ram.sv
// jedro_1_data_ram
//   Single-port data memory for the jedro_1 load/store unit, plus a sticky
//   "tohost" halt register used by simulation benches to detect end-of-test.
//
//   Pipeline:
//     - Accept edge: RAM is written or read, the access is classified, and
//       the counters and halt state are updated.
//     - Next edge: the response is registered onto rvalid_o, rdata_o and err_o.
//
// Ports
//   clk_i        clock, rising edge
//   rstn_i       synchronous active-low reset
//   req_i        request valid, sampled every cycle (no backpressure)
//   we_i         byte write enables, 4'b0000 = read
//   addr_i       byte address
//   wdata_i      write data, lane k = bits [8k+7:8k]
//   rvalid_o     response valid
//   rdata_o      read data (qualified by rvalid_o, holds otherwise)
//   err_o        access error (qualified by rvalid_o)
//   halt_o       sticky halt flag, set by the first full tohost write
//   halt_code_o  data of the first tohost write
//   rd_cnt_o     successful read count (wraps)
//   wr_cnt_o     successful write count incl. tohost writes (wraps)
module jedro_1_data_ram #(
  parameter int unsigned                ADDR_WIDTH      = 32,
  parameter int unsigned                DATA_WIDTH      = 32,
  parameter int unsigned                MEM_DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR       = '0,
  parameter logic [ADDR_WIDTH-1:0]      TOHOST_ADDR     = ADDR_WIDTH'(32'h1000_0000)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_i,
  input  logic [3:0]            we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  halt_o,
  output logic [DATA_WIDTH-1:0] halt_code_o,
  output logic [31:0]           rd_cnt_o,
  output logic [31:0]           wr_cnt_o
);

  localparam int unsigned WORD_AW = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] RAM_BYTES = (ADDR_WIDTH+1)'(4 * MEM_DEPTH_WORDS);

  typedef enum logic {RUN, HALTED} state_t;
  typedef enum logic [1:0] {SEL_ZERO, SEL_RAM, SEL_CODE} sel_t;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH:0]   offset;
  logic [WORD_AW-1:0]    word_idx;
  logic                  misaligned;
  logic                  is_write;
  logic                  ram_ok;
  logic                  tohost_ok;
  logic                  req_err;
  logic                  ram_we;
  logic                  tohost_wr;

  // One extra bit: an address below BASE_ADDR borrows into the top bit and
  // therefore compares above RAM_BYTES, so one compare covers both bounds.
  assign offset     = {1'b0, addr_i} - {1'b0, BASE_ADDR};
  assign word_idx   = offset[WORD_AW+1:2];
  assign misaligned = |addr_i[1:0];
  assign is_write   = |we_i;
  assign ram_ok     = (offset < RAM_BYTES) && !misaligned;
  // Reads of tohost are always fine; writes must cover all four lanes.
  assign tohost_ok  = (addr_i == TOHOST_ADDR) && !misaligned && (!is_write || (we_i == 4'hF));
  assign req_err    = !(ram_ok || tohost_ok);
  assign ram_we     = req_i && rstn_i && is_write && ram_ok;
  assign tohost_wr  = req_i && is_write && tohost_ok;

  // ---------------------------------------------------------------------------
  // RAM: byte-lane writes, registered read. Zero at power-up, untouched by reset.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS] = '{default: '0};
  logic [DATA_WIDTH-1:0] ram_q;

  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int k = 0; k < 4; k++) begin
        if (we_i[k]) mem[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (req_i && !is_write) ram_q <= mem[word_idx];
  end

  // ---------------------------------------------------------------------------
  // Halt FSM
  // ---------------------------------------------------------------------------
  state_t state_reg, state_next;
  logic   halt_set;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_reg <= RUN;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    halt_set   = 1'b0;
    case (state_reg)
      RUN: begin
        if (tohost_wr) begin
          state_next = HALTED;
          halt_set   = 1'b1;
        end
      end
      HALTED: state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Accept stage: classification, counters, halt code
  // ---------------------------------------------------------------------------
  logic                  v1_reg;
  logic                  err1_reg;
  sel_t                  sel1_reg;
  logic [DATA_WIDTH-1:0] halt_code_reg;
  logic [31:0]           rd_cnt_reg;
  logic [31:0]           wr_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      v1_reg        <= 1'b0;
      err1_reg      <= 1'b0;
      sel1_reg      <= SEL_ZERO;
      halt_code_reg <= '0;
      rd_cnt_reg    <= '0;
      wr_cnt_reg    <= '0;
    end else begin
      v1_reg <= req_i;
      if (req_i) begin
        err1_reg <= req_err;
        if (!is_write && ram_ok)         sel1_reg <= SEL_RAM;
        else if (!is_write && tohost_ok) sel1_reg <= SEL_CODE;
        else                             sel1_reg <= SEL_ZERO;
        if (!req_err) begin
          if (is_write) wr_cnt_reg <= wr_cnt_reg + 32'd1;
          else          rd_cnt_reg <= rd_cnt_reg + 32'd1;
        end
      end
      if (halt_set) halt_code_reg <= wdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Response stage
  // ---------------------------------------------------------------------------
  logic                  rvalid_reg;
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      rvalid_reg <= v1_reg;
      if (v1_reg) begin
        err_reg <= err1_reg;
        // The halt code can only change on a tohost write, which never sits
        // between a tohost read and its response, so the live value is exact.
        case (sel1_reg)
          SEL_RAM:  rdata_reg <= ram_q;
          SEL_CODE: rdata_reg <= halt_code_reg;
          default:  rdata_reg <= '0;
        endcase
      end
    end
  end

  assign rvalid_o    = rvalid_reg;
  assign err_o       = err_reg;
  assign rdata_o     = rdata_reg;
  assign halt_o      = (state_reg == HALTED);
  assign halt_code_o = halt_code_reg;
  assign rd_cnt_o    = rd_cnt_reg;
  assign wr_cnt_o    = wr_cnt_reg;

endmodule

// File: tb/tb_jedro_1_data_ram.sv
module tb_jedro_1_data_ram;

  localparam logic [31:0] TOHOST = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        halt;
  logic [31:0] halt_code;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  always #5 clk = ~clk;

  jedro_1_data_ram dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .err_o       (err),
    .halt_o      (halt),
    .halt_code_o (halt_code),
    .rd_cnt_o    (rd_cnt),
    .wr_cnt_o    (wr_cnt)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] addr;
  } resp_t;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  resp_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_rd = 0;
  int    exp_wr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request for the next rising edge; optionally register its
  // expected response with the scoreboard.
  task automatic send(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rdata, input logic exp_err, input bit push);
    @(posedge clk);
    #1;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    if (push) begin
      sb_q.push_back('{rdata: exp_rdata, err: exp_err, addr: a});
      if (!exp_err) begin
        if (w == 4'h0) exp_rd++;
        else           exp_wr++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      req = 1'b0;
      we  = 4'h0;
    end
  endtask

  task automatic drain_and_count(input string tag);
    idle(4);
    check({tag, "_pending"}, 32'(sb_q.size()), 32'd0);
    check({tag, "_rd_cnt"}, rd_cnt, 32'(exp_rd));
    check({tag, "_wr_cnt"}, wr_cnt, 32'(exp_wr));
  endtask

  // Response monitor: every rvalid pulse must match the oldest expectation.
  always @(negedge clk) begin
    resp_t e;
    if (rvalid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h expected no response", rdata);
      end else begin
        e = sb_q.pop_front();
        $display("rsp addr=%h rdata=%h err=%b (exp %h/%b)", e.addr, rdata, err, e.rdata, e.err);
        check("rsp_rdata", rdata, e.rdata);
        check("rsp_err", 32'(err), 32'(e.err));
      end
    end
  end

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{4'hF, 32'h10,   32'hDEAD_BEEF, 32'h0,         1'b0},
      '{4'h1, 32'h10,   32'h0000_0055, 32'h0,         1'b0},
      '{4'h0, 32'h10,   32'h0,         32'hDEAD_BE55, 1'b0},
      '{4'hF, 32'h0,    32'h1111_1111, 32'h0,         1'b0},
      '{4'hF, 32'h4,    32'h2222_2222, 32'h0,         1'b0},
      '{4'hF, 32'h8,    32'h3333_3333, 32'h0,         1'b0},
      '{4'hF, 32'hC,    32'h4444_4444, 32'h0,         1'b0},
      '{4'h0, 32'h0,    32'h0,         32'h1111_1111, 1'b0},
      '{4'h0, 32'h4,    32'h0,         32'h2222_2222, 1'b0},
      '{4'h0, 32'h8,    32'h0,         32'h3333_3333, 1'b0},
      '{4'h0, 32'hC,    32'h0,         32'h4444_4444, 1'b0},
      '{4'hF, 32'h20,   32'hA5A5_A5A5, 32'h0,         1'b0},
      '{4'h0, 32'h20,   32'h0,         32'hA5A5_A5A5, 1'b0},
      '{4'h4, 32'h10,   32'h12AA_3456, 32'h0,         1'b0},
      '{4'h0, 32'h10,   32'h0,         32'hDEAA_BE55, 1'b0},
      '{4'h0, 32'h30,   32'h0,         32'h0,         1'b0},
      '{4'h0, 32'h2,    32'h0,         32'h0,         1'b1},
      '{4'hF, 32'h1000, 32'hFFFF_FFFF, 32'h0,         1'b1},
      '{4'h0, 32'hFFC,  32'h0,         32'h0,         1'b0},
      '{4'h3, TOHOST,   32'h1234_5678, 32'h0,         1'b1},
      '{4'hF, 32'h11,   32'hFFFF_FFFF, 32'h0,         1'b1},
      '{4'h0, 32'h10,   32'h0,         32'hDEAA_BE55, 1'b0},
      '{4'h0, 32'h1000, 32'h0,         32'h0,         1'b1},
      '{4'h8, 32'hFFC,  32'hCC00_0000, 32'h0,         1'b0},
      '{4'h0, 32'hFFC,  32'h0,         32'hCC00_0000, 1'b0}
    };

    // Reset held 3 cycles with a full write presented: must be dropped.
    rstn  = 1'b0;
    req   = 1'b1;
    we    = 4'hF;
    addr  = 32'h30;
    wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    req  = 1'b0;
    we   = 4'h0;
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_halt_code", halt_code, 32'd0);
    check("rst_rd_cnt", rd_cnt, 32'd0);
    check("rst_wr_cnt", wr_cnt, 32'd0);

    // Table vectors, issued back-to-back.
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, 1'b1);
      if (i == 2) begin
        drain_and_count("byte_lanes");
        check("byte_lanes_wr2", wr_cnt, 32'd2);
        check("byte_lanes_rd1", rd_cnt, 32'd1);
      end
    end
    drain_and_count("table");
    check("no_halt_after_partial", 32'(halt), 32'd0);

    // Halt: first tohost write latches, second is accepted but ignored.
    send(4'hF, TOHOST, 32'h1, 32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    req = 1'b0;
    we  = 4'h0;
    check("halt_after_accept", 32'(halt), 32'd1);
    check("halt_code_after_accept", halt_code, 32'h1);
    send(4'hF, TOHOST, 32'h2, 32'h0, 1'b0, 1'b1);
    send(4'h0, TOHOST, 32'h0, 32'h1, 1'b0, 1'b1);
    send(4'hF, 32'h40, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1);
    send(4'h0, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
    drain_and_count("halted");
    check("halt_sticky", 32'(halt), 32'd1);
    check("halt_code_kept", halt_code, 32'h1);

    // A read whose response is still in flight when reset asserts is dropped.
    send(4'h0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    req  = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn   = 1'b1;
    exp_rd = 0;
    exp_wr = 0;
    check("reset_clears_halt", 32'(halt), 32'd0);
    check("reset_clears_code", halt_code, 32'd0);
    drain_and_count("post_reset");
    send(4'h0, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
    drain_and_count("ram_kept");

    // Write counter wrap.
    force dut.wr_cnt_reg = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.wr_cnt_reg;
    check("wrap_preload", wr_cnt, 32'hFFFF_FFFF);
    send(4'hF, 32'h44, 32'h0BAD_CAFE, 32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    req = 1'b0;
    we  = 4'h0;
    check("wr_cnt_wrap", wr_cnt, 32'h0);
    idle(4);
    check("final_pending", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jedro_1_data_ram.md
# jedro_1_data_ram

Single-port data-memory responder for the jedro_1 core's load/store unit: the slave end of the core's read/write data-memory interface. It accepts one request per cycle with no backpressure, returns read data one cycle later, and applies per-byte write enables. It also flags out-of-range and misaligned accesses, and provides a sticky "tohost" halt register that simulation benches poll for end-of-test.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, word width; fixed at 32, so there are 4 byte lanes
- MEM_DEPTH_WORDS, 1024, RAM depth in words
- BASE_ADDR, 32'h0000_0000, byte address of word 0; word-aligned
- TOHOST_ADDR, 32'h1000_0000, halt register address; must lie outside the RAM range

Ports:
- clk_i  in  1  clock; all logic is on the rising edge
- rstn_i  in  1  reset; synchronous, active-low
- req_i  in  1  request valid; sampled every cycle
- we_i  in  4  byte write enables; 4'b0000 means read
- addr_i  in  ADDR_WIDTH  byte address
- wdata_i  in  DATA_WIDTH  write data, lane k = bits [8k+7:8k]
- rvalid_o  out  1  response valid, exactly one cycle after an accepted request
- rdata_o  out  DATA_WIDTH  read data, qualified by rvalid_o
- err_o  out  1  access error, qualified by rvalid_o
- halt_o  out  1  sticky; set by a tohost write
- halt_code_o  out  DATA_WIDTH  value of the first tohost write
- rd_cnt_o  out  32  count of successful reads
- wr_cnt_o  out  32  count of successful writes

## Operation
- **Decode.**
  - In-range: BASE_ADDR <= addr_i < BASE_ADDR + 4*MEM_DEPTH_WORDS.
  - Word index: (addr_i - BASE_ADDR) >> 2.
  - Misaligned: addr_i[1:0] != 0. This is always an error, regardless of we_i.
- **Read** (we_i == 0):
  - In-range and aligned: rdata_o returns the full word and err_o = 0.
  - At TOHOST_ADDR: rdata_o = halt_code_o.
  - Otherwise: rdata_o = 0 and err_o = 1.
- **Write** (we_i != 0):
  - In-range and aligned: only lanes with we_i[k] = 1 are updated.
  - The response has rdata_o = 0 and err_o = 0.
  - Erroring writes modify nothing.
- **Tohost write.**
  - Requires addr_i == TOHOST_ADDR and we_i == 4'b1111.
  - State RUN -> HALTED: halt_o is set to 1 and halt_code_o is set to wdata_i.
  - In HALTED, further tohost writes are accepted (err_o = 0) but leave halt_code_o unchanged.
  - A partial write to TOHOST_ADDR sets err_o = 1 and causes no state change.
  - HALTED is left only by reset.
  - RAM accesses continue to work normally in HALTED.
- **Counters.**
  - rd_cnt_o increments on each non-error read; wr_cnt_o increments on each non-error write, including tohost writes.
  - Both wrap from 2^32-1 to 0.
  - Both update in the same edge as the request is accepted.
- **Reset** (rstn_i low at a rising edge):
  - rvalid_o = 0, err_o = 0, rdata_o = 0, halt_o = 0, halt_code_o = 0, rd_cnt_o = 0, wr_cnt_o = 0, state = RUN.
  - A request presented in a reset cycle is dropped: no write, no response next cycle.
  - RAM contents are not cleared by reset. They are zero-initialised at time 0.
  - A response already pending when reset asserts is suppressed.

## Timing
- Request accepted at edge N:
  - rvalid_o, rdata_o and err_o are valid after edge N+1 and held for one cycle.
  - rvalid_o = 0 in cycles with no accepted request, and rdata_o holds its last value.
- Back-to-back requests are supported at full throughput, one response per cycle, in order.
- Write at edge N followed by a read of the same word at edge N+1: the read returns the new data (write-first).
- halt_o and halt_code_o change after the edge that accepts the tohost write, one cycle before that write's rvalid_o.
- Counters are visible after the accept edge.

## Test plan
- **Reset:** hold rstn_i = 0 for 3 cycles with req_i = 1 and we_i = 4'hF -> all outputs 0, rvalid_o never 1, and a later read of that word returns 0.
- **Byte lanes:** write 32'hDEADBEEF with mask 4'hF to 0x10, then 32'h0000_0055 with mask 4'b0001 to 0x10, then read 0x10 -> rdata_o = 32'hDEADBE55, err_o = 0, wr_cnt_o = 2, rd_cnt_o = 1.
- **Back-to-back:** 4 consecutive writes to 0x0/0x4/0x8/0xC, then 4 consecutive reads -> 4 rvalid_o pulses on consecutive cycles, in order, with correct data. A write immediately followed by a read of the same word returns the new value.
- **Errors:**
  - Read 0x2 -> err_o = 1.
  - Write to 4*MEM_DEPTH_WORDS -> err_o = 1 and no memory change.
  - Partial write to TOHOST_ADDR -> err_o = 1 and halt_o = 0.
  - Counters unchanged in all three cases.
- **Halt:** write 32'h1 then 32'h2 to TOHOST_ADDR -> halt_o = 1 and halt_code_o = 32'h1 is retained. A read of TOHOST_ADDR returns 32'h1. After reset, halt_o = 0.
- **Counter wrap:** force wr_cnt_o to 32'hFFFF_FFFF, then perform one write -> wr_cnt_o = 0.
